// File: rtl/execute_stage.sv
// EX stage of the five-stage MIPS pipeline: ALU, branch target, dest-register select, EX/MEM register.
// Optional signed-overflow detection on R-type ADD/SUB is enabled with `define EX_OVERFLOW_EN.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  id_ex_wb,
    input  logic [2:0]  id_ex_mem,
    input  logic [3:0]  id_ex_execute,
    input  logic [31:0] id_ex_npc,
    input  logic [31:0] id_ex_readdat1,
    input  logic [31:0] id_ex_readdat2,
    input  logic [31:0] id_ex_sign_ext,
    input  logic [4:0]  id_ex_instr_bits_20_16,
    input  logic [4:0]  id_ex_instr_bits_15_11,
    output logic [1:0]  ex_mem_wb,
    output logic [2:0]  ex_mem_mem,
    output logic [31:0] ex_mem_branch_target,
    output logic        ex_mem_zero,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_readdat2,
    output logic [4:0]  ex_mem_write_reg
`ifdef EX_OVERFLOW_EN
    ,
    output logic        ex_mem_ovf
`endif
);

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [31:0] alu_eval(input logic [1:0] aluop, input logic [5:0] funct,
                                             input logic signed [31:0] a, input logic signed [31:0] b);
        logic [31:0] r;
        r = '0;
        case (aluop)
            2'b00: r = a + b;
            2'b01: r = a - b;
            2'b10: begin
                case (funct)
                    FN_ADD:  r = a + b;
                    FN_SUB:  r = a - b;
                    FN_AND:  r = a & b;
                    FN_OR:   r = a | b;
                    FN_SLT:  r = (a < b) ? 32'd1 : 32'd0;
                    default: r = '0;
                endcase
            end
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef EX_OVERFLOW_EN
    // Only R-type ADD/SUB trap; address and branch-compare arithmetic are allowed to wrap.
    function automatic logic ovf_eval(input logic [1:0] aluop, input logic [5:0] funct,
                                      input logic signed [31:0] a, input logic signed [31:0] b,
                                      input logic [31:0] r);
        logic o;
        o = 1'b0;
        if (aluop == 2'b10) begin
            if (funct == FN_ADD)
                o = (a[31] == b[31]) && (r[31] != a[31]);
            else if (funct == FN_SUB)
                o = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return o;
    endfunction
`endif

    logic              regdst_p0;
    logic [1:0]        aluop_p0;
    logic              alusrc_p0;
    logic signed [31:0] op_a_p0;
    logic signed [31:0] op_b_p0;
    logic [31:0]       alu_res_p0;
    logic [31:0]       branch_tgt_p0;
    logic [4:0]        write_reg_p0;
    logic              regwrite_p0;

    assign {regdst_p0, aluop_p0, alusrc_p0} = id_ex_execute;
    assign op_a_p0       = id_ex_readdat1;
    assign op_b_p0       = alusrc_p0 ? id_ex_sign_ext : id_ex_readdat2;
    assign alu_res_p0    = alu_eval(aluop_p0, id_ex_sign_ext[5:0], op_a_p0, op_b_p0);
    assign branch_tgt_p0 = id_ex_npc + id_ex_sign_ext;
    assign write_reg_p0  = regdst_p0 ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;

`ifdef EX_OVERFLOW_EN
    logic ovf_p0;
    assign ovf_p0      = ovf_eval(aluop_p0, id_ex_sign_ext[5:0], op_a_p0, op_b_p0, alu_res_p0);
    assign regwrite_p0 = id_ex_wb[1] & ~ovf_p0;
`else
    assign regwrite_p0 = id_ex_wb[1];
`endif

    // EX/MEM register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_wb            <= '0;
            ex_mem_mem           <= '0;
            ex_mem_branch_target <= '0;
            ex_mem_zero          <= 1'b0;
            ex_mem_alu_result    <= '0;
            ex_mem_readdat2      <= '0;
            ex_mem_write_reg     <= '0;
`ifdef EX_OVERFLOW_EN
            ex_mem_ovf           <= 1'b0;
`endif
        end else begin
            ex_mem_branch_target <= branch_tgt_p0;
            ex_mem_zero          <= (alu_res_p0 == 32'd0);
            ex_mem_alu_result    <= alu_res_p0;
            ex_mem_readdat2      <= id_ex_readdat2;
            ex_mem_write_reg     <= write_reg_p0;
`ifdef EX_OVERFLOW_EN
            ex_mem_ovf           <= ovf_p0;
`endif
            if (flush) begin
                ex_mem_wb  <= '0;
                ex_mem_mem <= '0;
            end else begin
                ex_mem_wb  <= {regwrite_p0, id_ex_wb[0]};
                ex_mem_mem <= id_ex_mem;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed cases plus random instructions against a behavioural model.
// Build with +define+EX_OVERFLOW_EN to exercise the overflow variant.
module tb_execute_stage;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] se;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } stim_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] bt;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  wreg;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0, flush = 1'b0;
    logic [1:0]  id_ex_wb = '0;
    logic [2:0]  id_ex_mem = '0;
    logic [3:0]  id_ex_execute = '0;
    logic [31:0] id_ex_npc = '0, id_ex_readdat1 = '0, id_ex_readdat2 = '0, id_ex_sign_ext = '0;
    logic [4:0]  id_ex_instr_bits_20_16 = '0, id_ex_instr_bits_15_11 = '0;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_mem;
    logic [31:0] ex_mem_branch_target, ex_mem_alu_result, ex_mem_readdat2;
    logic        ex_mem_zero;
    logic [4:0]  ex_mem_write_reg;
`ifdef EX_OVERFLOW_EN
    logic        ex_mem_ovf;
`endif

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem), .id_ex_execute(id_ex_execute),
        .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
        .id_ex_sign_ext(id_ex_sign_ext),
        .id_ex_instr_bits_20_16(id_ex_instr_bits_20_16), .id_ex_instr_bits_15_11(id_ex_instr_bits_15_11),
        .ex_mem_wb(ex_mem_wb), .ex_mem_mem(ex_mem_mem), .ex_mem_branch_target(ex_mem_branch_target),
        .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_readdat2(ex_mem_readdat2), .ex_mem_write_reg(ex_mem_write_reg)
`ifdef EX_OVERFLOW_EN
        , .ex_mem_ovf(ex_mem_ovf)
`endif
    );

    // Reference model: MIPS EX semantics written as plain integer arithmetic.
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        longint sa, sb, wide;
        logic [31:0] b;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        ovf;
        e = '0;
        if (s.rst) return e;
        aluop = s.ex[2:1];
        funct = s.se[5:0];
        b     = s.ex[0] ? s.se : s.rd2;
        sa    = longint'($signed(s.rd1));
        sb    = longint'($signed(b));
        ovf   = 1'b0;
        wide  = 0;
        if (aluop == 2'b00)      wide = sa + sb;
        else if (aluop == 2'b01) wide = sa - sb;
        else if (aluop == 2'b10) begin
            if (funct == 6'h20) begin wide = sa + sb; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            else if (funct == 6'h22) begin wide = sa - sb; ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            else if (funct == 6'h24) wide = longint'(s.rd1 & b);
            else if (funct == 6'h25) wide = longint'(s.rd1 | b);
            else if (funct == 6'h2A) wide = (sa < sb) ? 1 : 0;
        end
        e.alu  = wide[31:0];
        e.zero = (e.alu == 0);
        e.bt   = 32'(longint'(s.npc) + longint'(s.se));
        e.rd2  = s.rd2;
        e.wreg = s.ex[3] ? s.rd : s.rt;
`ifdef EX_OVERFLOW_EN
        e.ovf  = ovf;
        e.wb   = s.flush ? 2'b00 : {s.wb[1] & ~ovf, s.wb[0]};
`else
        e.ovf  = 1'b0;
        e.wb   = s.flush ? 2'b00 : s.wb;
`endif
        e.mem  = s.flush ? 3'b000 : s.mem;
        return e;
    endfunction

    function automatic stim_t mk(input logic r, input logic f, input logic [1:0] wb, input logic [2:0] mem,
                                 input logic [3:0] ex, input logic [31:0] npc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] se, input logic [4:0] rt,
                                 input logic [4:0] rd);
        stim_t s;
        s.rst = r; s.flush = f; s.wb = wb; s.mem = mem; s.ex = ex; s.npc = npc;
        s.rd1 = a; s.rd2 = b; s.se = se; s.rt = rt; s.rd = rd;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        @(negedge clk);
        rst = s.rst; flush = s.flush;
        id_ex_wb = s.wb; id_ex_mem = s.mem; id_ex_execute = s.ex; id_ex_npc = s.npc;
        id_ex_readdat1 = s.rd1; id_ex_readdat2 = s.rd2; id_ex_sign_ext = s.se;
        id_ex_instr_bits_20_16 = s.rt; id_ex_instr_bits_15_11 = s.rd;
        exp_q.push_back(model(s));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s vec=%0d got=0x%08h expected=0x%08h", nm, n_vec, act, req);
        end
    endtask

    // Monitor: one registered result per edge, compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                chk("wb",        32'(ex_mem_wb),         32'(e.wb));
                chk("mem",       32'(ex_mem_mem),        32'(e.mem));
                chk("branch_tgt", ex_mem_branch_target,  e.bt);
                chk("zero",      32'(ex_mem_zero),       32'(e.zero));
                chk("alu",       ex_mem_alu_result,      e.alu);
                chk("readdat2",  ex_mem_readdat2,        e.rd2);
                chk("write_reg", 32'(ex_mem_write_reg),  32'(e.wreg));
`ifdef EX_OVERFLOW_EN
                chk("ovf",       32'(ex_mem_ovf),        32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        stim_t s;
        int    k;
        // reset held two cycles with busy inputs, then ADD
        apply(mk(1, 0, 2'b11, 3'b111, 4'b1111, 32'h55, 32'h1234, 32'h9876, 32'h20, 5'd3, 5'd9));
        apply(mk(1, 0, 2'b11, 3'b111, 4'b1100, 32'h55, 32'h1234, 32'h9876, 32'h22, 5'd3, 5'd9));
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd7, 5'd2));
        // BEQ, LW
        apply(mk(0, 0, 2'b00, 3'b100, 4'b0010, 32'd2, 32'd3, 32'd3, 32'd8, 5'd3, 5'd0));
        apply(mk(0, 0, 2'b11, 3'b010, 4'b0001, 32'd3, 32'h100, 32'h0, 32'd2, 5'd2, 5'd0));
        // SLT, AND, OR, unknown funct
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1100, 32'd4, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd4));
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1100, 32'd5, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd5));
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1100, 32'd6, 32'hF0F0, 32'hFF00, 32'h25, 5'd1, 5'd6));
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1100, 32'd7, 32'hF0F0, 32'hFF00, 32'h3F, 5'd1, 5'd7));
        // aluop 11, flushed SW, rst+flush together, normal recovery
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1110, 32'd8, 32'h77, 32'h11, 32'h20, 5'd1, 5'd8));
        apply(mk(0, 1, 2'b00, 3'b001, 4'b0001, 32'd9, 32'h200, 32'hAA, 32'd4, 5'd5, 5'd0));
        apply(mk(1, 1, 2'b10, 3'b001, 4'b1100, 32'd9, 32'h200, 32'hAA, 32'h20, 5'd5, 5'd3));
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1100, 32'd10, 32'd9, 32'd4, 32'h22, 5'd5, 5'd3));
        // overflow cases: R-type ADD/SUB, then aluop 00/01 which never flag
        apply(mk(0, 0, 2'b10, 3'b000, 4'b1100, 32'd11, 32'h7FFFFFFF, 32'd1, 32'h20, 5'd5, 5'd12));
        apply(mk(0, 0, 2'b11, 3'b000, 4'b1100, 32'd12, 32'h80000000, 32'd1, 32'h22, 5'd5, 5'd13));
        apply(mk(0, 0, 2'b10, 3'b000, 4'b0000, 32'd13, 32'h7FFFFFFF, 32'd1, 32'h20, 5'd14, 5'd0));
        apply(mk(0, 0, 2'b10, 3'b100, 4'b0010, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd2, 5'd15, 5'd0));
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s.rst   = ($urandom_range(0, 39) == 0);
            s.flush = ($urandom_range(0, 9) == 0);
            s.wb    = 2'($urandom);
            s.mem   = 3'($urandom);
            s.ex    = 4'($urandom);
            s.npc   = $urandom;
            k = $urandom_range(0, 3);
            s.rd1   = (k == 0) ? 32'h7FFFFFFF - 32'($urandom_range(0, 3)) : (k == 1) ? 32'h80000000 + 32'($urandom_range(0, 3)) : $urandom;
            s.rd2   = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
            s.se    = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 5))
                    0: s.se[5:0] = 6'h20;
                    1: s.se[5:0] = 6'h22;
                    2: s.se[5:0] = 6'h24;
                    3: s.se[5:0] = 6'h25;
                    4: s.se[5:0] = 6'h2A;
                    default: s.se[5:0] = 6'($urandom);
                endcase
            end
            s.rt    = 5'($urandom);
            s.rd    = 5'($urandom);
            apply(s);
        end
        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 10) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (exp_q.size() > 0) begin
                n_miss++;
                $display("FAIL drain pending=%0d expected=0", exp_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
